floating_point_accum_seq: RTL and testbench

Stimulus sequencer for the floating-point accumulator onboard test. It walks the operand ROM and the tlast ROM in lock-step, absorbing their 1-cycle registered read latency. It streams {tdata, tlast} beats into the accumulator's AXI-Stream input under full tready backpressure. It also counts accumulator results and signals completion once every tlast-terminated packet has returned a result.

---
 rtl/floating_point_pkg.sv | 17 +
 rtl/floating_point_accum_seq_fifo.sv | 57 +++++
 rtl/floating_point_accum_seq.sv | 156 +++++++++++++++
 tb/tb_floating_point_accum_seq.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/floating_point_pkg.sv
// Shared types and constants for the floating-point accumulator stimulus sequencer.
package floating_point_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 5;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + CNT_W'(1);
    endfunction

endpackage

// File: rtl/floating_point_accum_seq_fifo.sv
// Four-entry synchronous FIFO holding {tlast, tdata} beats between the ROM pipeline and the stream output.
module floating_point_accum_seq_fifo
    import floating_point_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [2:0]       count,
    output logic             empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == 3'd0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (count != 3'(FIFO_DEPTH));
    assign head    = mem[rd_ptr];

    // Storage carries no reset; the output side masks it while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/floating_point_accum_seq.sv
// Stimulus sequencer: walks operand/tlast ROMs, streams beats under backpressure, counts results.
// Optional wrap-around looping is enabled by defining FLT_ACCUM_SEQ_LOOP_EN.
module floating_point_accum_seq
    import floating_point_pkg::*;
#(
    parameter int DEPTH  = 10,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rom_tdata,
    input  logic              rom_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    input  logic              s_res_tvalid,
    output logic [CNT_W-1:0]  pkts_sent,
    output logic [CNT_W-1:0]  res_rcvd
);

`ifdef FLT_ACCUM_SEQ_LOOP_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
`else
    localparam logic [ADDR_W-1:0] PRE_LAST_ADDR = ADDR_W'(DEPTH - 2);
`endif

    state_t            state;
    state_t            state_next;
    logic              issue;
    logic [ADDR_W-1:0] addr_next;
    logic              done_set;
    logic              vld_p1;
    logic              vld_p2;
    logic [2:0]        fifo_count;
    logic              fifo_empty;
    logic [DATA_W:0]   fifo_head;
    logic [2:0]        inflight;
    logic              credit_ok;
    logic              start_accept;
    logic              xfer;

    // Beats in the FIFO plus those still in the ROM pipeline must never exceed the FIFO depth.
    assign inflight     = fifo_count + {2'b00, vld_p1} + {2'b00, vld_p2};
    assign credit_ok    = (inflight < 3'(FIFO_DEPTH));
    assign start_accept = (state == IDLE) && start;
    assign xfer         = m_axis_tvalid & m_axis_tready;

    assign m_axis_tvalid = ~fifo_empty;
    assign m_axis_tdata  = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
    assign m_axis_tlast  = fifo_empty ? 1'b0 : fifo_head[DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        addr_next  = rd_addr;
        done_set   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    issue      = 1'b1;
                    addr_next  = '0;
                end
            end
            RUN: begin
`ifdef FLT_ACCUM_SEQ_LOOP_EN
                if ((rd_addr == LAST_ADDR) && !start) begin
                    state_next = DRAIN;
                end else if (credit_ok) begin
                    issue     = 1'b1;
                    addr_next = (rd_addr == LAST_ADDR) ? '0 : rd_addr + ADDR_W'(1);
                end
`else
                if (credit_ok) begin
                    issue     = 1'b1;
                    addr_next = rd_addr + ADDR_W'(1);
                    if (rd_addr == PRE_LAST_ADDR) begin
                        state_next = DRAIN;
                    end
                end
`endif
            end
            DRAIN: begin
                if (fifo_empty && !vld_p1 && !vld_p2 && (res_rcvd == pkts_sent)) begin
                    state_next = IDLE;
                    done_set   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // p1: address presented to the ROMs; p2: ROM output valid, written to the FIFO next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr   <= '0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pkts_sent <= '0;
            res_rcvd  <= '0;
        end else begin
            vld_p1 <= issue;
            vld_p2 <= vld_p1;
            done   <= done_set;
            if (issue) begin
                rd_addr <= addr_next;
            end
            if (start_accept) begin
                busy <= 1'b1;
            end else if (done) begin
                busy <= 1'b0;
            end
            if (start_accept) begin
                pkts_sent <= '0;
                res_rcvd  <= '0;
            end else begin
                if (xfer && m_axis_tlast) begin
                    pkts_sent <= sat_inc(pkts_sent);
                end
                if (s_res_tvalid && (state != IDLE)) begin
                    res_rcvd <= sat_inc(res_rcvd);
                end
            end
        end
    end

    floating_point_accum_seq_fifo #(
        .WIDTH(DATA_W + 1)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (vld_p2),
        .push_data({rom_tlast, rom_tdata}),
        .pop      (xfer),
        .head     (fifo_head),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_floating_point_accum_seq.sv
// Self-checking bench for floating_point_accum_seq; the loop scenario runs when FLT_ACCUM_SEQ_LOOP_EN is defined.
module tb_floating_point_accum_seq;

    localparam int DEPTH  = 10;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rom_tdata = '0;
    logic              rom_tlast = 1'b0;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b1;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tlast;
    logic              s_res_tvalid = 1'b0;
    logic [4:0]        pkts_sent;
    logic [4:0]        res_rcvd;

    floating_point_accum_seq #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .rd_addr      (rd_addr),
        .rom_tdata    (rom_tdata),
        .rom_tlast    (rom_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tlast (m_axis_tlast),
        .s_res_tvalid (s_res_tvalid),
        .pkts_sent    (pkts_sent),
        .res_rcvd     (res_rcvd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [DATA_W-1:0] rom_data [16];
    logic              rom_tl   [16];
    logic [DATA_W:0]   beats [$];
    int                xfer_edge [$];
    int                res_due [$];
    int                done_cnt = 0;
    int                stab_err = 0;
    int                wraps = 0;
    int                held = 0;
    bit                withhold = 1'b0;
    bit                prev_stall = 1'b0;
    logic [DATA_W:0]   prev_beat = '0;
    logic [ADDR_W-1:0] prev_addr = '0;

    always @(posedge clk) cyc = cyc + 1;

    // Registered ROM pair with one cycle of read latency.
    always @(posedge clk) begin
        rom_tdata <= rom_data[rd_addr];
        rom_tlast <= rom_tl[rd_addr];
    end

    // Accumulator stand-in: one result strobe per tlast beat, three cycles later.
    always @(posedge clk) begin
        #1;
        s_res_tvalid = 1'b0;
        if (res_due.size() > 0 && res_due[0] <= cyc) begin
            s_res_tvalid = 1'b1;
            void'(res_due.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!m_axis_tvalid || {m_axis_tlast, m_axis_tdata} !== prev_beat))
                stab_err++;
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_beat  = {m_axis_tlast, m_axis_tdata};
            if (m_axis_tvalid && m_axis_tready) begin
                beats.push_back({m_axis_tlast, m_axis_tdata});
                xfer_edge.push_back(cyc + 1);
                if (m_axis_tlast) begin
                    if (withhold) held++;
                    else res_due.push_back(cyc + 3);
                end
            end
            if (done) done_cnt++;
            if (busy && prev_addr == ADDR_W'(DEPTH - 1) && rd_addr == '0) wraps++;
            prev_addr = rd_addr;
        end
    end

    task automatic load_rom();
        for (int a = 0; a < 16; a++) begin
            rom_data[a] = $urandom;
            rom_tl[a]   = (a == 7) || (a == 9);
        end
    endtask

    task automatic clear_monitor();
        beats.delete();
        xfer_edge.delete();
        res_due.delete();
        done_cnt = 0;
        stab_err = 0;
        wraps = 0;
        held = 0;
    endtask

    task automatic pulse_start(output int s);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        s = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_beats(input int n, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (beats.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        m_axis_tready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast} !== '0) begin
            failures++;
            $display("FAIL reset_stream got tvalid=%0b tdata=%h tlast=%0b want all 0", m_axis_tvalid, m_axis_tdata, m_axis_tlast);
        end
        checks++;
        if ({busy, done, rd_addr, pkts_sent, res_rcvd} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl got busy=%0b done=%0b rd_addr=%0d pkts=%0d res=%0d want all 0", busy, done, rd_addr, pkts_sent, res_rcvd);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_monitor();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, m_axis_tvalid, rd_addr} !== '0) begin
            failures++;
            $display("FAIL idle_after_reset got busy=%0b tvalid=%0b rd_addr=%0d want 0", busy, m_axis_tvalid, rd_addr);
        end
    endtask

    task automatic test_basic_pass();
        int s;
        bit ok;
        logic [DATA_W:0] exp;
        load_rom();
        clear_monitor();
        m_axis_tready = 1'b1;
        pulse_start(s);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL busy_on_start got=%0b want=1", busy); end
        @(negedge clk);
        checks++;
        if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL latency_early got tvalid=%0b want=0", m_axis_tvalid); end
        @(negedge clk);
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== rom_data[0]) begin
            failures++;
            $display("FAIL latency_first got tvalid=%0b tdata=%h want 1 %h", m_axis_tvalid, m_axis_tdata, rom_data[0]);
        end
        wait_done(100, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL basic_done_timeout got no done want done within 100 cycles"); end
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL busy_during_done got=%0b want=1", busy); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL busy_fall got busy=%0b done=%0b want 0 0", busy, done); end
        repeat (3) @(negedge clk);
        checks++;
        if (beats.size() != DEPTH) begin failures++; $display("FAIL basic_beat_count got=%0d want=%0d", beats.size(), DEPTH); end
        for (int i = 0; i < beats.size() && i < DEPTH; i++) begin
            exp = {rom_tl[i], rom_data[i]};
            checks++;
            if (beats[i] !== exp) begin failures++; $display("FAIL basic_beat%0d got=%h want=%h", i, beats[i], exp); end
            checks++;
            if (xfer_edge[i] != s + 3 + i) begin failures++; $display("FAIL basic_edge%0d got=%0d want=%0d", i, xfer_edge[i], s + 3 + i); end
        end
        checks++;
        if (pkts_sent !== 5'd2 || res_rcvd !== 5'd2 || done_cnt != 1) begin
            failures++;
            $display("FAIL basic_counts got pkts=%0d res=%0d dones=%0d want 2 2 1", pkts_sent, res_rcvd, done_cnt);
        end
    endtask

    task automatic test_backpressure();
        int s;
        int n;
        int exp_addr;
        bit ok;
        logic [DATA_W:0] exp;
        load_rom();
        clear_monitor();
        m_axis_tready = 1'b1;
        pulse_start(s);
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_axis_tready = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        n = beats.size();
        exp_addr = (n + 3 > DEPTH - 1) ? DEPTH - 1 : n + 3;
        checks++;
        if (rd_addr !== ADDR_W'(exp_addr)) begin failures++; $display("FAIL bp_stall_addr got=%0d want=%0d", rd_addr, exp_addr); end
        checks++;
        if (m_axis_tvalid !== 1'b1) begin failures++; $display("FAIL bp_tvalid_held got=%0b want=1", m_axis_tvalid); end
        for (int i = 0; i < 300 && beats.size() < DEPTH; i++) begin
            @(posedge clk); #1;
            m_axis_tready = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        m_axis_tready = 1'b1;
        wait_done(100, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL bp_done_timeout got no done want done within 100 cycles"); end
        checks++;
        if (stab_err != 0) begin failures++; $display("FAIL bp_stability got=%0d unstable cycles want=0", stab_err); end
        checks++;
        if (beats.size() != DEPTH) begin failures++; $display("FAIL bp_beat_count got=%0d want=%0d", beats.size(), DEPTH); end
        for (int i = 0; i < beats.size() && i < DEPTH; i++) begin
            exp = {rom_tl[i], rom_data[i]};
            checks++;
            if (beats[i] !== exp) begin failures++; $display("FAIL bp_beat%0d got=%h want=%h", i, beats[i], exp); end
        end
        checks++;
        if (pkts_sent !== 5'd2 || res_rcvd !== 5'd2) begin failures++; $display("FAIL bp_counts got pkts=%0d res=%0d want 2 2", pkts_sent, res_rcvd); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_start_ignored();
        int s;
        bit ok;
        load_rom();
        clear_monitor();
        m_axis_tready = 1'b1;
        pulse_start(s);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (pkts_sent == 5'd1) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL ign_first_pkt_timeout got pkts=%0d want 1", pkts_sent); end
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (pkts_sent < 5'd1 || busy !== 1'b1) begin failures++; $display("FAIL ign_counters_kept got pkts=%0d busy=%0b want >=1 1", pkts_sent, busy); end
        wait_done(100, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL ign_done_timeout got no done want done within 100 cycles"); end
        repeat (4) @(negedge clk);
        checks++;
        if (beats.size() != DEPTH || pkts_sent !== 5'd2 || res_rcvd !== 5'd2 || done_cnt != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ign_totals got beats=%0d pkts=%0d res=%0d dones=%0d busy=%0b want %0d 2 2 1 0", beats.size(), pkts_sent, res_rcvd, done_cnt, busy, DEPTH);
        end
    endtask

    task automatic test_reset_mid_pass();
        int s;
        bit ok;
        logic [DATA_W:0] exp;
        load_rom();
        clear_monitor();
        m_axis_tready = 1'b1;
        pulse_start(s);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        clear_monitor();
        @(negedge clk);
        checks++;
        if ({m_axis_tvalid, busy, pkts_sent, rd_addr} !== '0) begin
            failures++;
            $display("FAIL midrst_clear got tvalid=%0b busy=%0b pkts=%0d rd_addr=%0d want 0", m_axis_tvalid, busy, pkts_sent, rd_addr);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        load_rom();
        clear_monitor();
        pulse_start(s);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL midrst_stale_beat got tvalid=%0b want=0", m_axis_tvalid); end
        @(negedge clk);
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== rom_data[0]) begin
            failures++;
            $display("FAIL midrst_first got tvalid=%0b tdata=%h want 1 %h", m_axis_tvalid, m_axis_tdata, rom_data[0]);
        end
        wait_done(100, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL midrst_done_timeout got no done want done within 100 cycles"); end
        checks++;
        if (beats.size() != DEPTH) begin failures++; $display("FAIL midrst_beat_count got=%0d want=%0d", beats.size(), DEPTH); end
        for (int i = 0; i < beats.size() && i < DEPTH; i++) begin
            exp = {rom_tl[i], rom_data[i]};
            checks++;
            if (beats[i] !== exp) begin failures++; $display("FAIL midrst_beat%0d got=%h want=%h", i, beats[i], exp); end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_withheld_results();
        int s;
        bit ok;
        load_rom();
        clear_monitor();
        m_axis_tready = 1'b1;
        withhold = 1'b1;
        pulse_start(s);
        wait_beats(DEPTH, 100, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL wh_beats_timeout got=%0d want=%0d", beats.size(), DEPTH); end
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done_cnt != 0 || pkts_sent !== 5'd2 || res_rcvd !== 5'd0) begin
            failures++;
            $display("FAIL wh_waiting got busy=%0b dones=%0d pkts=%0d res=%0d want 1 0 2 0", busy, done_cnt, pkts_sent, res_rcvd);
        end
        res_due.push_back(cyc);
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done_cnt != 0 || res_rcvd !== 5'd1) begin
            failures++;
            $display("FAIL wh_one_result got busy=%0b dones=%0d res=%0d want 1 0 1", busy, done_cnt, res_rcvd);
        end
        res_due.push_back(cyc);
        wait_done(20, ok);
        checks++;
        if (!ok || res_rcvd !== 5'd2) begin failures++; $display("FAIL wh_done got done_seen=%0b res=%0d want 1 2", ok, res_rcvd); end
        withhold = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done_cnt != 1) begin failures++; $display("FAIL wh_end got busy=%0b dones=%0d want 0 1", busy, done_cnt); end
    endtask

`ifdef FLT_ACCUM_SEQ_LOOP_EN
    task automatic test_loop();
        bit ok;
        int passes;
        int tl_per_pass;
        int exp_pkts;
        logic [DATA_W:0] exp;
        load_rom();
        clear_monitor();
        m_axis_tready = 1'b1;
        tl_per_pass = 0;
        for (int a = 0; a < DEPTH; a++) if (rom_tl[a]) tl_per_pass++;
        @(posedge clk); #1;
        start = 1'b1;
        wait_beats(25, 300, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL loop_beats_timeout got=%0d want>=25", beats.size()); end
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(300, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL loop_done_timeout got no done want done within 300 cycles"); end
        passes = beats.size() / DEPTH;
        exp_pkts = (passes * tl_per_pass > 31) ? 31 : passes * tl_per_pass;
        checks++;
        if (beats.size() % DEPTH != 0 || passes < 3) begin
            failures++;
            $display("FAIL loop_whole_passes got beats=%0d want multiple of %0d and >=3 passes", beats.size(), DEPTH);
        end
        for (int i = 0; i < beats.size(); i++) begin
            exp = {rom_tl[i % DEPTH], rom_data[i % DEPTH]};
            checks++;
            if (beats[i] !== exp) begin failures++; $display("FAIL loop_beat%0d got=%h want=%h", i, beats[i], exp); end
        end
        checks++;
        if (pkts_sent !== 5'(exp_pkts) || res_rcvd !== 5'(exp_pkts)) begin
            failures++;
            $display("FAIL loop_counts got pkts=%0d res=%0d want %0d %0d", pkts_sent, res_rcvd, exp_pkts, exp_pkts);
        end
        checks++;
        if (wraps != passes - 1) begin failures++; $display("FAIL loop_wraps got=%0d want=%0d", wraps, passes - 1); end
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_basic_pass();
        test_backpressure();
        test_start_ignored();
        test_reset_mid_pass();
        test_withheld_results();
`ifdef FLT_ACCUM_SEQ_LOOP_EN
        test_loop();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
